// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master data-memory arbiter: sequencer states,
// owner ids and arbitration modes.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      ARB_M0 = 1'b0,
      ARB_M1 = 1'b1
   } arb_owner_e;

   localparam int unsigned PRIO_RR    = 0;
   localparam int unsigned PRIO_FIXED = 1;

   localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-requester grant logic: round-robin on last owner, or fixed priority
// with master 0 winning every tie. Grant is one-hot, zero when nobody asks.
module arb_rr2
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned PRIO_MODE = PRIO_RR
) (
   input  logic       req0_i,
   input  logic       req1_i,
   input  arb_owner_e last_owner_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = '0;
      if (req0_i && req1_i) begin
         if ((PRIO_MODE == PRIO_FIXED) || (last_owner_i == ARB_M1)) begin
            grant_o = 2'b01;
         end else begin
            grant_o = 2'b10;
         end
      end else if (req0_i) begin
         grant_o = 2'b01;
      end else if (req1_i) begin
         grant_o = 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between the core data port (m0) and an
// external master (m1) through a request/ack handshake and a 4-state sequencer.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              core_hold_req_o,
   output logic              mem_cs_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

   arb_state_e        state_q, state_d;
   arb_owner_e        owner_q, owner_d;
   arb_owner_e        last_owner_q, last_owner_d;
   logic              we_lat_q, we_lat_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              m0_ack_q, m0_ack_d;
   logic              m1_ack_q, m1_ack_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic [1:0]        grant;
   logic              sel_m1;

   arb_rr2 #(
      .PRIO_MODE(PRIO_MODE)
   ) u_arb (
      .req0_i      (m0_req_i),
      .req1_i      (m1_req_i),
      .last_owner_i(last_owner_q),
      .grant_o     (grant)
   );

   assign sel_m1 = grant[1];

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_lat_d     = we_lat_q;
      cnt_d        = cnt_q;
      mem_cs_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      m0_ack_d     = 1'b0;
      m1_ack_d     = 1'b0;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      unique case (state_q)
         ARB_IDLE: begin
            // Address/wdata latch is folded into the registered mem_* outputs,
            // which are only non-zero during the ISSUE cycle.
            if (|grant) begin
               owner_d      = sel_m1 ? ARB_M1 : ARB_M0;
               last_owner_d = sel_m1 ? ARB_M1 : ARB_M0;
               we_lat_d     = sel_m1 ? m1_we_i : m0_we_i;
               mem_cs_d     = 1'b1;
               mem_we_d     = sel_m1 ? m1_we_i : m0_we_i;
               mem_addr_d   = sel_m1 ? m1_addr_i : m0_addr_i;
               mem_wdata_d  = sel_m1 ? m1_wdata_i : m0_wdata_i;
               state_d      = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (we_lat_q) begin
               m0_ack_d = (owner_q == ARB_M0);
               m1_ack_d = (owner_q == ARB_M1);
               state_d  = ARB_RESP;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (cnt_q == '0) begin
               if (owner_q == ARB_M0) begin
                  m0_rdata_d = mem_rdata_i;
                  m0_ack_d   = 1'b1;
               end else begin
                  m1_rdata_d = mem_rdata_i;
                  m1_ack_d   = 1'b1;
               end
               state_d = ARB_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         owner_q      <= ARB_M0;
         last_owner_q <= ARB_M1;
         we_lat_q     <= 1'b0;
         cnt_q        <= '0;
         mem_cs_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_lat_q     <= we_lat_d;
         cnt_q        <= cnt_d;
         mem_cs_q     <= mem_cs_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         m0_ack_q     <= m0_ack_d;
         m1_ack_q     <= m1_ack_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign m0_ack_o        = m0_ack_q;
   assign m1_ack_o        = m1_ack_q;
   assign m0_rdata_o      = m0_rdata_q;
   assign m1_rdata_o      = m1_rdata_q;
   assign mem_cs_o        = mem_cs_q;
   assign mem_we_o        = mem_we_q;
   assign mem_addr_o      = mem_addr_q;
   assign mem_wdata_o     = mem_wdata_q;
   assign core_hold_req_o = m0_req_i & ~m0_ack_q;

endmodule
